// File: rtl/div_responder.sv
// Multi-cycle 32/32 restoring divider with a start/ready handshake and flush/annul abort.
// Optional macro DIV_EARLY_EXIT_EN: finish right away when |divisor| > |dividend|.
module div_responder (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    input  logic        signed_div_i,
    output logic        ready_o,
    output logic [63:0] result_o
);

    typedef enum logic [1:0] {
        IDLE,
        BYZERO,
        ON,
        DONE
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] dq_q, dq_d;      // {partial remainder, dividend bits / quotient bits}
    logic [31:0] dvs_q, dvs_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;

    logic        abort;
    logic        early_exit;
    logic [31:0] op1_mag, op2_mag;
    logic [33:0] trial;
    logic [63:0] step;
    logic [31:0] quo_fix, rem_fix;

    assign abort = flush | annul_i;

    assign op1_mag = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    assign op2_mag = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

    // Trial subtract of the divisor from {remainder, next dividend bit}; bit 33 set means borrow.
    assign trial = {1'b0, dq_q[63:31]} - {2'b00, dvs_q};
    assign step  = trial[33] ? {dq_q[62:0], 1'b0}
                             : {trial[31:0], dq_q[30:0], 1'b1};

`ifdef DIV_EARLY_EXIT_EN
    assign early_exit = (cnt_q == 6'd0) && (dvs_q > dq_q[31:0]);
`else
    assign early_exit = 1'b0;
`endif

    assign quo_fix = q_neg_q ? (~dq_q[31:0] + 32'd1)  : dq_q[31:0];
    assign rem_fix = r_neg_q ? (~dq_q[63:32] + 32'd1) : dq_q[63:32];

    assign ready_o  = (state_q == DONE) && !abort;
    assign result_o = ready_o ? {rem_fix, quo_fix} : 64'h0;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        dq_d    = dq_q;
        dvs_d   = dvs_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;

        case (state_q)
            IDLE: begin
                if (start_i && !abort) begin
                    dq_d    = {32'h0, op1_mag};
                    dvs_d   = op2_mag;
                    q_neg_d = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                    r_neg_d = signed_div_i & opdata1_i[31];
                    cnt_d   = 6'd0;
                    state_d = (opdata2_i == 32'h0) ? BYZERO : ON;
                end
            end
            BYZERO: begin
                dq_d    = 64'h0;
                state_d = DONE;
            end
            ON: begin
                // Counts 0..31 doing one step each; the cycle at 32 only hands over to DONE.
                if (cnt_q == 6'd32) begin
                    state_d = DONE;
                end else if (early_exit) begin
                    dq_d    = {dq_q[31:0], 32'h0};
                    state_d = DONE;
                end else begin
                    dq_d  = step;
                    cnt_d = cnt_q + 6'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            state_d = IDLE;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            dq_q    <= 64'h0;
            dvs_q   <= 32'h0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dq_q    <= dq_d;
            dvs_q   <= dvs_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
        end
    end

endmodule

// File: tb/tb_div_responder.sv
// Scoreboarded random bench for div_responder: driver pushes expected results, monitor pops on ready_o.
module tb_div_responder;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic        signed_div_i;
    logic        ready_o;
    logic [63:0] result_o;

    typedef struct {
        logic [63:0] res;
        int          due;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    div_responder dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .opdata1_i   (opdata1_i),
        .opdata2_i   (opdata2_i),
        .start_i     (start_i),
        .annul_i     (annul_i),
        .signed_div_i(signed_div_i),
        .ready_o     (ready_o),
        .result_o    (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint to_long(input logic [31:0] v, input logic s);
        if (s) return longint'($signed(v));
        return longint'({32'h0, v});
    endfunction

    // Reference: plain integer division, truncating toward zero, remainder follows the dividend.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb, q, r;
        if (b == 32'h0) return 64'h0;
        sa = to_long(a, s);
        sb = to_long(b, s);
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int lat(input logic [31:0] a, input logic [31:0] b, input logic s);
`ifdef DIV_EARLY_EXIT_EN
        longint ma, mb;
`endif
        if (b == 32'h0) return 1;
`ifdef DIV_EARLY_EXIT_EN
        ma = to_long(a, s);
        mb = to_long(b, s);
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
        if (mb > ma) return 1;
`endif
        return 33;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            if (ready_o) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_ready", {63'h0, ready_o}, 64'h0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("result", result_o, e.res);
                    check("latency", 64'(cyc), 64'(e.due));
                end
            end else begin
                check("idle_result_zero", result_o, 64'h0);
            end
        end
    end

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input bit use_const, input logic [63:0] cexp);
        exp_t e;
        int   n;
        bit   seen;
        @(negedge clk);
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = s;
        start_i      = 1'b1;
        @(posedge clk);
        #1;
        n     = cyc;
        e.res = use_const ? cexp : model(a, b, s);
        e.due = n + lat(a, b, s);
        sb_q.push_back(e);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (ready_o) seen = 1'b1;
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            signed_div_i = 1'($urandom_range(0, 1));
        end
        start_i = 1'b0;
        if (!seen) check("ready_timeout", 64'h0, 64'h1);
    endtask

    task automatic run_abort(input logic [31:0] a, input logic [31:0] b, input int delay,
                             input bit use_annul);
        @(negedge clk);
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = 1'b0;
        start_i      = 1'b1;
        @(posedge clk);
        repeat (delay) @(posedge clk);
        #1;
        if (use_annul) annul_i = 1'b1;
        else flush = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        flush   = 1'b0;
        annul_i = 1'b0;
        repeat (40) @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a, b;
        logic        s;
        rst          = 1'b0;
        flush        = 1'b0;
        annul_i      = 1'b0;
        start_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'h0;
        opdata2_i    = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", {63'h0, ready_o}, 64'h0);
        check("reset_result", result_o, 64'h0);
        @(negedge clk);
        rst = 1'b1;

        run_div(32'd7, 32'd2, 1'b0, 1'b1, 64'h00000001_00000003);
        run_div(32'hFFFFFFF9, 32'd2, 1'b1, 1'b1, 64'hFFFFFFFF_FFFFFFFD);
        run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 64'h00000000_80000000);
        run_div(32'h1234, 32'd0, 1'b0, 1'b1, 64'h0);
        run_div(32'd10, 32'd3, 1'b0, 1'b1, 64'h00000001_00000003);
        run_div(32'd5, 32'd9, 1'b0, 1'b1, 64'h00000005_00000000);
        run_div(32'hFFFFFFFB, 32'd9, 1'b1, 1'b1, 64'hFFFFFFFB_00000000);
        run_div(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, 64'h00000000_FFFFFFFF);

        // Aborts: flush mid-division, annul mid-division, flush while DONE is presented.
        run_abort(32'd100, 32'd7, 10, 1'b0);
        run_div(32'd100, 32'd7, 1'b0, 1'b1, 64'h00000002_0000000E);
        run_abort(32'd100, 32'd7, 20, 1'b1);
        run_abort(32'd100, 32'd7, 33, 1'b0);
        run_div(32'd100, 32'd7, 1'b1, 1'b1, 64'h00000002_0000000E);

        // Async reset while the result is being presented, then mid-division.
        @(negedge clk);
        opdata1_i = 32'd50000; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
        @(posedge clk);
        repeat (33) @(posedge clk);
        #2;
        check("pre_reset_ready", {63'h0, ready_o}, 64'h1);
        rst = 1'b0;
        start_i = 1'b0;
        #1;
        check("async_reset_ready", {63'h0, ready_o}, 64'h0);
        check("async_reset_result", result_o, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        opdata1_i = 32'd77777; opdata2_i = 32'd5; start_i = 1'b1;
        repeat (12) @(posedge clk);
        #3;
        rst = 1'b0;
        start_i = 1'b0;
        #1;
        check("mid_reset_ready", {63'h0, ready_o}, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        run_div(32'd9, 32'd3, 1'b0, 1'b1, 64'h00000000_00000003);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0: b = $urandom;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'h0;
                3: begin a = 32'($urandom_range(0, 200)); b = 32'($urandom_range(201, 5000)); end
                default: b = {{16{a[31]}}, 16'($urandom)};
            endcase
            run_div(a, b, s, 1'b0, 64'h0);
        end

        repeat (5) @(posedge clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
